// File: rtl/akiko_c2p_sequencer.sv
// ----------------------------------------------------------------------------
// akiko_c2p_sequencer
//
// Shares the Akiko C2P register ($B80038) between the CPU and an autonomous
// chunky-to-planar conversion engine. While idle, CPU accesses pass straight
// through to the C2P unit. Once a job starts, the engine owns the unit and
// processes one block at a time. For each 128-bit block it does the following:
//   - It pulls 8 chunky words from the source stream and writes them to the unit.
//   - It then reads 16 planar words back and pushes them to the destination stream.
// While the job runs, the CPU is held off with cpu_wait. This keeps the unit's
// write pointer from being corrupted mid-block.
//
// Parameters
//   LEN_W        width of job_len / block counter
//
// Ports
//   clk, reset   system clock; synchronous active-high reset
//   cpu_sel_c2p  CPU access strobe to $B80038; cpu_rd selects read/write
//   cpu_data_in  CPU write data
//   cpu_wait     CPU access refused this cycle (engine owns the unit)
//   start        job start pulse, honoured only when idle
//   job_len      number of 128-bit blocks, sampled with start
//   busy         engine not idle
//   done         one-cycle pulse at job completion
//   src_*        chunky word stream in (valid/ready)
//   dst_*        planar word stream out (registered valid/data, ready in)
//   c2p_sel      select to the C2P unit; c2p_rd 1=read (shifts), 0=write
//   c2p_wdata    write data to the unit
//   c2p_rdata    combinational read data from the unit
//
// Configuration
//   AKIKO_C2P_DONE_IRQ_EN  adds irq (sticky completion flag) and irq_ack.
// ----------------------------------------------------------------------------
module akiko_c2p_sequencer #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_sel_c2p,
    input  logic             cpu_rd,
    input  logic [15:0]      cpu_data_in,
    output logic             cpu_wait,
    input  logic             start,
    input  logic [LEN_W-1:0] job_len,
    output logic             busy,
    output logic             done,
    input  logic             src_valid,
    input  logic [15:0]      src_data,
    output logic             src_ready,
    output logic             dst_valid,
    output logic [15:0]      dst_data,
    input  logic             dst_ready,
    output logic             c2p_sel,
    output logic             c2p_rd,
    output logic [15:0]      c2p_wdata,
    input  logic [15:0]      c2p_rdata
`ifdef AKIKO_C2P_DONE_IRQ_EN
    ,
    output logic             irq,
    input  logic             irq_ack
`endif
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SYNC  = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_FLUSH = 3'd4;

    logic [2:0]       state;
    logic [LEN_W-1:0] blocks_left;
    logic [2:0]       wcnt;
    logic [3:0]       rcnt;
    logic             rd_fire;

    assign busy = (state != ST_IDLE);

    // NOTE: every output gets a default before the case, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        c2p_sel   = 1'b0;
        c2p_rd    = 1'b0;
        c2p_wdata = 16'h0000;
        src_ready = 1'b0;
        cpu_wait  = 1'b0;
        rd_fire   = 1'b0;
        case (state)
            ST_IDLE: begin
                c2p_sel   = cpu_sel_c2p;
                c2p_rd    = cpu_rd;
                c2p_wdata = cpu_data_in;
            end
            ST_SYNC: begin
                // Dummy read: resets any partial write pointer left by the CPU.
                c2p_sel = 1'b1;
                c2p_rd  = 1'b1;
            end
            ST_LOAD: begin
                if (src_valid) begin
                    c2p_sel   = 1'b1;
                    c2p_wdata = src_data;
                    src_ready = 1'b1;
                end
            end
            ST_DRAIN: begin
                // Read only when the output register is free or emptying now.
                rd_fire = !dst_valid || dst_ready;
                c2p_sel = rd_fire;
                c2p_rd  = rd_fire;
            end
            default: ;
        endcase
        // Outside IDLE, CPU strobes are refused, never forwarded.
        if (state != ST_IDLE)
            cpu_wait = cpu_sel_c2p;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            blocks_left <= '0;
            wcnt        <= 3'd0;
            rcnt        <= 4'd0;
            dst_valid   <= 1'b0;
            dst_data    <= 16'h0000;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;

            if (rd_fire) begin
                dst_data  <= c2p_rdata;
                dst_valid <= 1'b1;
            end else begin
                dst_valid <= dst_valid & ~dst_ready;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (job_len != '0) begin
                            blocks_left <= job_len;
                            state       <= ST_SYNC;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ST_SYNC: begin
                    wcnt  <= 3'd0;
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (src_valid) begin
                        wcnt <= wcnt + 3'd1;
                        if (wcnt == 3'd7) begin
                            rcnt  <= 4'd0;
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (rd_fire) begin
                        rcnt <= rcnt + 4'd1;
                        if (rcnt == 4'd15) begin
                            // The 16 reads already reset the unit's write pointer.
                            blocks_left <= blocks_left - LEN_W'(1);
                            wcnt        <= 3'd0;
                            state       <= (blocks_left == LEN_W'(1)) ? ST_FLUSH : ST_LOAD;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (!dst_valid || dst_ready) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef AKIKO_C2P_DONE_IRQ_EN
    // Sticky completion flag. The done cycle has priority over a coincident
    // ack, so an ack that races completion cannot lose the interrupt.
    always_ff @(posedge clk) begin
        if (reset)
            irq <= 1'b0;
        else if (done)
            irq <= 1'b1;
        else if (irq_ack)
            irq <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_akiko_c2p_sequencer.sv
// ----------------------------------------------------------------------------
// tb_akiko_c2p_sequencer
//
// Self-checking bench for akiko_c2p_sequencer (default build, no irq ports).
// A small behavioural stand-in for the C2P unit supplies c2p_rdata. Expected
// destination words are computed per job from the chunky source words.
// ----------------------------------------------------------------------------
module tb_akiko_c2p_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_sel_c2p = 1'b0;
    logic        cpu_rd = 1'b0;
    logic [15:0] cpu_data_in = 16'h0000;
    logic        cpu_wait;
    logic        start = 1'b0;
    logic [15:0] job_len = 16'h0000;
    logic        busy;
    logic        done;
    logic        src_valid = 1'b0;
    logic [15:0] src_data = 16'h0000;
    logic        src_ready;
    logic        dst_valid;
    logic [15:0] dst_data;
    logic        dst_ready = 1'b0;
    logic        c2p_sel;
    logic        c2p_rd;
    logic [15:0] c2p_wdata;
    logic [15:0] c2p_rdata;

    int checks = 0;
    int failures = 0;

    logic [15:0] src_q[$];

    always #5 clk = ~clk;

    akiko_c2p_sequencer #(.LEN_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_sel_c2p (cpu_sel_c2p),
        .cpu_rd      (cpu_rd),
        .cpu_data_in (cpu_data_in),
        .cpu_wait    (cpu_wait),
        .start       (start),
        .job_len     (job_len),
        .busy        (busy),
        .done        (done),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .src_ready   (src_ready),
        .dst_valid   (dst_valid),
        .dst_data    (dst_data),
        .dst_ready   (dst_ready),
        .c2p_sel     (c2p_sel),
        .c2p_rd      (c2p_rd),
        .c2p_wdata   (c2p_wdata),
        .c2p_rdata   (c2p_rdata)
    );

    // Planar word k of a block of eight chunky words. Reads 0-7 return two
    // bit-columns each (column 15-2k in the high byte, 14-2k in the low byte,
    // chunky word 0 in the MSB of each byte). Reads 8-15 return the AND of
    // the block, so a single set bit reads back as zeros there and all-ones
    // stays all-ones.
    function automatic logic [15:0] planar_word(input logic [7:0][15:0] w, input int k);
        logic [15:0] r;
        r = 16'h0000;
        if (k < 8) begin
            for (int p = 0; p < 8; p++) begin
                r[15-p] = w[p][15-2*k];
                r[7-p]  = w[p][14-2*k];
            end
        end else begin
            r = 16'hFFFF;
            for (int p = 0; p < 8; p++) r = r & w[p];
        end
        return r;
    endfunction

    // Stand-in C2P unit: writes fill the next slice, reads step the column
    // index, any read resets the write pointer and any write restarts reads.
    logic [7:0][15:0] u_slice = '0;
    int               u_wptr = 0;
    int               u_ridx = 0;

    assign c2p_rdata = planar_word(u_slice, u_ridx);

    always @(posedge clk) begin
        if (c2p_sel) begin
            if (c2p_rd) begin
                u_ridx <= u_ridx + 1;
                u_wptr <= 0;
            end else begin
                u_slice[u_wptr] <= c2p_wdata;
                u_wptr          <= (u_wptr + 1) % 8;
                u_ridx          <= 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_block(input logic [15:0] w0, input logic [15:0] rest, input logic [15:0] w7);
        src_q.push_back(w0);
        for (int i = 1; i < 7; i++) src_q.push_back(rest);
        src_q.push_back(w7);
    endtask

    task automatic push_random(input int blocks);
        for (int i = 0; i < 8 * blocks; i++) src_q.push_back(16'($urandom));
    endtask

    // Runs one job using src_q. Source valid probability vprob (percent).
    // rmode: 0 dst_ready=1, 1 toggling, 2 random. cpu_poke strobes the CPU
    // all job long; spurious pulses start while busy; abort_at>=0 asserts
    // reset when the block read counter equals abort_at.
    task automatic run_job(input int len, input int vprob, input int rmode,
                           input bit cpu_poke, input bit spurious, input int abort_at);
        logic [15:0]      exp_q[$];
        logic [15:0]      got_q[$];
        logic [7:0][15:0] blk;
        int  src_idx, reads, writes, leaks, src_bad, accept_cyc, done_cyc, busy_at_done;
        bit  seen_done;
        int  budget;

        exp_q.delete();
        got_q.delete();
        for (int b = 0; b < len; b++) begin
            for (int i = 0; i < 8; i++) blk[i] = src_q[8*b+i];
            for (int k = 0; k < 16; k++) exp_q.push_back(planar_word(blk, k));
        end
        src_idx = 0; reads = 0; writes = 0; leaks = 0; src_bad = 0;
        accept_cyc = -1; done_cyc = -2; busy_at_done = 1; seen_done = 0;
        budget = 200 * len + 50;

        for (int cyc = 0; cyc < budget && !seen_done; cyc++) begin
            @(negedge clk);
            start       = (cyc == 0) || (spurious && ($urandom_range(0, 3) == 0));
            job_len     = (cyc == 0) ? 16'(len) : 16'($urandom);
            src_valid   = (src_idx < src_q.size()) && ($urandom_range(0, 99) < vprob);
            src_data    = src_valid ? src_q[src_idx] : 16'($urandom);
            dst_ready   = (rmode == 0) ? 1'b1 : (rmode == 1) ? cyc[0] : 1'($urandom);
            cpu_sel_c2p = cpu_poke && (cyc > 0);
            cpu_rd      = 1'($urandom);
            cpu_data_in = 16'hDEAD;
            #1;
            if (cyc > 0 && !busy) begin
                start       = 1'b0;
                cpu_sel_c2p = 1'b0;
                #1;
            end
            if (cpu_sel_c2p && busy && !cpu_wait) leaks++;
            if (c2p_sel && c2p_rd) reads++;
            if (c2p_sel && !c2p_rd) writes++;
            if (src_ready) begin
                if (!src_valid) src_bad++;
                src_idx++;
            end
            if (dst_valid && dst_ready) begin
                got_q.push_back(dst_data);
                accept_cyc = cyc;
            end
            if (done) begin
                seen_done    = 1;
                done_cyc     = cyc;
                busy_at_done = busy;
            end
            if (abort_at >= 0 && reads - 1 == abort_at + 1) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                start = 1'b0;
                src_valid = 1'b0;
                cpu_sel_c2p = 1'b0;
                #1;
                check("abort_busy", busy, 0);
                check("abort_dst_valid", dst_valid, 0);
                check("abort_done", done, 0);
                check("abort_c2p_sel", c2p_sel, 0);
                @(negedge clk);
                #1;
                check("abort_no_done_later", done, 0);
                check("abort_idle_later", busy, 0);
                src_q.delete();
                return;
            end
        end
        start = 1'b0; src_valid = 1'b0; dst_ready = 1'b0; cpu_sel_c2p = 1'b0;

        check("done_seen", 32'(seen_done), 1);
        check("busy_at_done", busy_at_done, 0);
        check("done_after_last_accept", done_cyc, accept_cyc + 1);
        check("word_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("dst_word[%0d]", i), (i < got_q.size()) ? got_q[i] : 32'hBAD0, exp_q[i]);
        check("c2p_reads", reads, 1 + 16 * len);
        check("c2p_writes", writes, 8 * len);
        check("src_consumed", src_idx, 8 * len);
        check("src_ready_without_valid", src_bad, 0);
        check("cpu_leak_while_busy", leaks, 0);
        @(negedge clk);
        #1;
        check("done_one_cycle", done, 0);
        src_q.delete();
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dst_valid", dst_valid, 0);
        check("rst_dst_data", dst_data, 0);
        check("rst_cpu_wait", cpu_wait, 0);
        check("rst_src_ready", src_ready, 0);
        check("rst_c2p_sel", c2p_sel, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single MSB in word 0 -> 8000 then zeros
        push_block(16'h8000, 16'h0000, 16'h0000);
        run_job(1, 100, 0, 0, 0, -1);

        // Single LSB in word 7 -> 0001 at index 7
        push_block(16'h0000, 16'h0000, 16'h0001);
        run_job(1, 100, 0, 0, 0, -1);

        // Two all-ones blocks with toggling backpressure
        push_block(16'hFFFF, 16'hFFFF, 16'hFFFF);
        push_block(16'hFFFF, 16'hFFFF, 16'hFFFF);
        run_job(2, 100, 1, 0, 0, -1);

        // CPU passthrough: one read then three partial writes
        @(negedge clk);
        cpu_sel_c2p = 1'b1; cpu_rd = 1'b1; cpu_data_in = 16'h5A5A;
        #1;
        check("pass_rd_sel", c2p_sel, 1);
        check("pass_rd_rd", c2p_rd, 1);
        check("pass_rd_wait", cpu_wait, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cpu_rd = 1'b0; cpu_data_in = 16'h1230 + 16'(i);
            #1;
            check("pass_wr_sel", c2p_sel, 1);
            check("pass_wr_rd", c2p_rd, 0);
            check("pass_wr_data", c2p_wdata, 16'h1230 + 16'(i));
        end
        @(negedge clk);
        cpu_sel_c2p = 1'b0;
        // Job after partial CPU writes, CPU hammering the register throughout
        push_block(16'h8000, 16'h0000, 16'h0000);
        run_job(1, 70, 0, 1, 0, -1);

        // Zero-length job
        @(negedge clk);
        start = 1'b1; job_len = 16'h0000;
        #1;
        check("zero_len_c2p_sel", c2p_sel, 0);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("zero_len_done", done, 1);
        check("zero_len_busy", busy, 0);
        check("zero_len_c2p_sel_next", c2p_sel, 0);
        @(negedge clk);
        #1;
        check("zero_len_done_pulse", done, 0);
        check("zero_len_busy_next", busy, 0);

        // Reset at rcnt=5 of the first block, then a clean job
        push_random(2);
        run_job(2, 100, 0, 0, 0, 5);
        push_random(1);
        run_job(1, 100, 0, 0, 0, -1);

        // Randomised jobs: stalls on both sides, spurious start, CPU pokes
        for (int j = 0; j < 4; j++) begin
            int len;
            len = $urandom_range(1, 3);
            push_random(len);
            run_job(len, 60, 2, 1'($urandom), 1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
